// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared widths, size codes, FSM states and alignment helper
package mem_access_unit_pkg;
  localparam int WORD = 64;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;
  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;
  function automatic logic is_aligned(input logic [2:0] a, input size_t s);
    return s == SZ_B ? 1'b1 : s == SZ_H ? !a[0] : s == SZ_W ? a[1:0] == 2'b00 : a == 3'b000;
  endfunction
endpackage

// File: rtl/mem_access_unit_load_align.sv
// mem_access_unit_load_align: selects the addressed lane of a read doubleword and extends it
//   i_rdata  read doubleword      i_off  byte offset within the doubleword
//   i_size   access size          i_sext sign-extend (ignored for dword)
//   o_data   extended load value
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [WORD-1:0] i_rdata,
  input  logic [2:0]      i_off,
  input  size_t           i_size,
  input  logic            i_sext,
  output logic [WORD-1:0] o_data
);
  logic [WORD-1:0] w_sh;
  // Accesses are aligned, so shifting by the byte offset lands any lane at bit 0.
  assign w_sh = i_rdata >> {i_off, 3'b000};
  assign o_data = i_size == SZ_B ? {{56{i_sext & w_sh[7]}}, w_sh[7:0]} :
                  i_size == SZ_H ? {{48{i_sext & w_sh[15]}}, w_sh[15:0]} :
                  i_size == SZ_W ? {{32{i_sext & w_sh[31]}}, w_sh[31:0]} : w_sh;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: LEGv8 memory stage driving a 64-bit ready/valid data-memory bus
//   control in : start, mem_read, mem_write, size, sign_ext, address, store_data
//   status out : busy, done, load_data, misaligned, bus_error
//   bus        : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb out; mem_ready, mem_rdata in
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      size,
  input  logic            sign_ext,
  input  logic [WORD-1:0] address,
  input  logic [WORD-1:0] store_data,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] load_data,
  output logic            misaligned,
  output logic            bus_error,
  output logic            mem_req,
  output logic            mem_we,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  output logic [7:0]      mem_wstrb,
  input  logic            mem_ready,
  input  logic [WORD-1:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT);
  state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [2:0] r_off, w_off_n;
  size_t r_size, w_size_n, w_size;
  logic r_sext, w_sext_n;
  logic w_done_n, w_mis_n, w_berr_n, w_req_n, w_we_n;
  logic [WORD-1:0] w_addr_n, w_wdata_n, w_load_n, w_load, w_wdata;
  logic [7:0] w_wstrb_n, w_wstrb;
  assign w_size = size_t'(size);
  assign w_wdata = w_size == SZ_B ? {8{store_data[7:0]}} :
                   w_size == SZ_H ? {4{store_data[15:0]}} :
                   w_size == SZ_W ? {2{store_data[31:0]}} : store_data;
  assign w_wstrb = w_size == SZ_B ? 8'h01 << address[2:0] :
                   w_size == SZ_H ? 8'h03 << address[2:0] :
                   w_size == SZ_W ? 8'h0F << address[2:0] : 8'hFF;
  mem_access_unit_load_align u_align (
    .i_rdata (mem_rdata),
    .i_off   (r_off),
    .i_size  (r_size),
    .i_sext  (r_sext),
    .o_data  (w_load)
  );
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_off_n   = r_off;
    w_size_n  = r_size;
    w_sext_n  = r_sext;
    w_done_n  = 1'b0;
    w_mis_n   = 1'b0;
    w_berr_n  = 1'b0;
    w_req_n   = mem_req;
    w_we_n    = mem_we;
    w_addr_n  = mem_addr;
    w_wdata_n = mem_wdata;
    w_wstrb_n = mem_wstrb;
    w_load_n  = load_data;
    case (r_state)
      IDLE: if (start && (mem_read || mem_write)) begin
        if (mem_read && mem_write) begin
          w_state_n = ERR;
          w_berr_n  = 1'b1;
        end else if (!is_aligned(address[2:0], w_size)) begin
          w_state_n = ERR;
          w_mis_n   = 1'b1;
        end else begin
          w_state_n = REQ;
          w_cnt_n   = '0;
          w_req_n   = 1'b1;
          w_we_n    = mem_write;
          w_addr_n  = {address[WORD-1:3], 3'b000};
          w_wdata_n = w_wdata;
          w_wstrb_n = mem_write ? w_wstrb : 8'h00;
          w_off_n   = address[2:0];
          w_size_n  = w_size;
          w_sext_n  = sign_ext;
        end
      end
      REQ: if (mem_ready) begin
        w_state_n = RESP;
        w_req_n   = 1'b0;
        w_we_n    = 1'b0;
        w_done_n  = 1'b1;
        w_load_n  = mem_we ? load_data : w_load;
      end else if (r_cnt == CW'(TIMEOUT - 1)) begin
        w_state_n = ERR;
        w_req_n   = 1'b0;
        w_we_n    = 1'b0;
        w_berr_n  = 1'b1;
      end else begin
        w_cnt_n = r_cnt + 1'b1;
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_off      <= '0;
      r_size     <= SZ_B;
      r_sext     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      load_data  <= '0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_off      <= w_off_n;
      r_size     <= w_size_n;
      r_sext     <= w_sext_n;
      busy       <= w_state_n != IDLE;
      done       <= w_done_n;
      misaligned <= w_mis_n;
      bus_error  <= w_berr_n;
      mem_req    <= w_req_n;
      mem_we     <= w_we_n;
      mem_addr   <= w_addr_n;
      mem_wdata  <= w_wdata_n;
      mem_wstrb  <= w_wstrb_n;
      load_data  <= w_load_n;
    end
endmodule
